// File: rtl/ua_receive_pkg.sv
// UART receive shared definitions: state encodings,
// frame geometry and a log2 helper for counter sizing.
package ua_receive_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int UA_DATA_BITS  = 8;
  localparam int UA_FRAME_BITS = 10;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int log2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ua_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Ports: i_clk, i_rst_n (async low), i_d in, o_q synchronized out.
module ua_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ua_receive.sv
// UART 8N1 receiver with a one-entry ready/valid output register.
// Ports: Clock, Reset (async low), SIn serial in, DataOut/DataOutValid/
// DataOutReady handshake; FrameError when UA_RX_FRAMING_ERR_EN is defined.
module ua_receive
  import ua_receive_pkg::*;
#(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  input  logic       DataOutReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid
`ifdef UA_RX_FRAMING_ERR_EN
  ,
  output logic       FrameError
`endif
);

  localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
  localparam int SampleTime        = SymbolEdgeTime / 2;
  localparam int ClockCounterWidth = log2(SymbolEdgeTime);
  localparam int CW                = ClockCounterWidth;

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SampleTime - 1);
  localparam logic [CW-1:0] EDGE_LAST   = CW'(SymbolEdgeTime - 1);

  logic          w_rxs;
  logic [1:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;

  logic w_samp_start;
  logic w_edge;
  logic w_stop_hit;
  logic w_accept;
  logic w_room;
  logic w_load;

  ua_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk  (Clock),
    .i_rst_n(Reset),
    .i_d    (SIn),
    .o_q    (w_rxs)
  );

  always_comb begin
    w_samp_start = (r_state == START)
                && (r_clk_cnt == SAMPLE_LAST);
    w_edge       = (r_clk_cnt == EDGE_LAST);
    w_stop_hit   = (r_state == STOP) && w_edge;
    w_accept     = r_valid && DataOutReady;
    // A full register that is being drained this
    // cycle can take the new byte.
    w_room       = !r_valid || w_accept;
`ifdef UA_RX_FRAMING_ERR_EN
    w_load       = w_stop_hit && w_room;
`else
    w_load       = w_stop_hit && w_rxs && w_room;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!w_rxs) r_state <= START;
        end
        START: begin
          if (w_samp_start) begin
            r_clk_cnt <= '0;
            r_state   <= w_rxs ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_edge) begin
            r_shift   <= {w_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_clk_cnt <= '0;
            if (r_bit_cnt == 4'(UA_DATA_BITS - 1))
              r_state <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // Back to IDLE at mid-stop so the next start
          // edge is seen half a bit early.
          if (w_edge) begin
            r_clk_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef UA_RX_FRAMING_ERR_EN
  logic r_ferr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ferr <= 1'b0;
    end else if (w_load) begin
      r_ferr <= !w_rxs;
    end
  end

  assign FrameError = r_ferr;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign DataOut      = r_data;
  assign DataOutValid = r_valid;

endmodule

// File: tb/tb_ua_receive.sv
// Directed self-checking bench for ua_receive at 10 clocks per bit.
// Honours UA_RX_FRAMING_ERR_EN when defined at compile time.
module tb_ua_receive;

  logic       Clock;
  logic       Reset;
  logic       SIn;
  logic       DataOutReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
`ifdef UA_RX_FRAMING_ERR_EN
  logic       FrameError;
`endif

  int checks   = 0;
  int failures = 0;

  int cyc       = 0;
  int t0        = 0;
  int rise_cyc  = 0;
  int rx_cnt    = 0;
  int hold_err  = 0;
  logic [7:0] rx_last = 8'h00;
  logic       rx_ferr = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_acc   = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  ua_receive #(
    .ClockFreq(1_000_000),
    .BaudRate (100_000)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SIn         (SIn),
    .DataOutReady(DataOutReady),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid)
`ifdef UA_RX_FRAMING_ERR_EN
    ,
    .FrameError  (FrameError)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Observer: samples mid-cycle, records accepted
  // bytes and any change of a held output.
  always begin
    @(negedge Clock);
    #1;
    if (prev_valid && !prev_acc && DataOut !== prev_data)
      hold_err++;
    if (DataOutValid && (!prev_valid || prev_acc))
      rise_cyc = cyc;
    if (DataOutValid && DataOutReady) begin
      rx_cnt++;
      rx_last = DataOut;
`ifdef UA_RX_FRAMING_ERR_EN
      rx_ferr = FrameError;
`endif
    end
    prev_valid = DataOutValid;
    prev_acc   = DataOutValid && DataOutReady;
    prev_data  = DataOut;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    SIn = 1'b0;
    t0  = cyc;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      SIn = b[i];
      idle(10);
    end
    SIn = stop;
    idle(10);
    SIn = 1'b1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    DataOutReady = 1'b1;
    SIn = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      SIn = ~SIn;
      idle(1);
    end
    checks++;
    if (DataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", DataOutValid);
    end
    checks++;
    if (DataOut !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", DataOut);
    end
`ifdef UA_RX_FRAMING_ERR_EN
    checks++;
    if (FrameError !== 1'b0) begin
      failures++;
      $display("FAIL reset_ferr got=%b exp=0", FrameError);
    end
`endif
    SIn = 1'b1;
    idle(3);
    Reset = 1'b1;
    idle(30);
    checks++;
    if (DataOutValid !== 1'b0 || rx_cnt !== 0) begin
      failures++;
      $display("FAIL reset_idle valid=%b cnt=%0d exp 0/0",
               DataOutValid, rx_cnt);
    end
  endtask

  task automatic test_single;
    int c0;
    c0 = rx_cnt;
    send_frame(8'hA5, 1'b1);
    idle(5);
    checks++;
    if (rx_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", rx_cnt - c0);
    end
    checks++;
    if (rx_last !== 8'hA5) begin
      failures++;
      $display("FAIL single_data got=%h exp=a5", rx_last);
    end
    checks++;
    if (rise_cyc - t0 < 97 || rise_cyc - t0 > 99) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=98+-1",
               rise_cyc - t0);
    end
    checks++;
    if (DataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=0", DataOutValid);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = rx_cnt;
    DataOutReady = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(10);
    checks++;
    if (DataOutValid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold_valid got=%b exp=1", DataOutValid);
    end
    checks++;
    if (DataOut !== 8'h00) begin
      failures++;
      $display("FAIL b2b_hold_data got=%h exp=00", DataOut);
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL b2b_stable got=%0d exp=0", hold_err);
    end
    DataOutReady = 1'b1;
    idle(2);
    checks++;
    if (DataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drop got=%b exp=0", DataOutValid);
    end
    checks++;
    if (rx_last !== 8'h00) begin
      failures++;
      $display("FAIL b2b_data got=%h exp=00", rx_last);
    end
    idle(20);
    checks++;
    if (rx_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL b2b_overrun got=%0d exp=1", rx_cnt - c0);
    end
  endtask

  task automatic test_false_start;
    int c0;
    c0 = rx_cnt;
    SIn = 1'b0;
    idle(3);
    SIn = 1'b1;
    idle(30);
    checks++;
    if (rx_cnt - c0 !== 0 || DataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL false_start cnt=%0d valid=%b exp 0/0",
               rx_cnt - c0, DataOutValid);
    end
    send_frame(8'h3C, 1'b1);
    idle(5);
    checks++;
    if (rx_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL after_false_count got=%0d exp=1",
               rx_cnt - c0);
    end
    checks++;
    if (rx_last !== 8'h3C) begin
      failures++;
      $display("FAIL after_false_data got=%h exp=3c", rx_last);
    end
  endtask

  task automatic test_framing;
    int c0;
    c0 = rx_cnt;
    send_frame(8'h5A, 1'b0);
    idle(30);
`ifdef UA_RX_FRAMING_ERR_EN
    checks++;
    if (rx_cnt - c0 !== 1 || rx_last !== 8'h5A) begin
      failures++;
      $display("FAIL ferr_deliver cnt=%0d data=%h exp 1/5a",
               rx_cnt - c0, rx_last);
    end
    checks++;
    if (rx_ferr !== 1'b1) begin
      failures++;
      $display("FAIL ferr_flag got=%b exp=1", rx_ferr);
    end
    c0 = rx_cnt;
`else
    checks++;
    if (rx_cnt - c0 !== 0) begin
      failures++;
      $display("FAIL ferr_drop got=%0d exp=0", rx_cnt - c0);
    end
`endif
    send_frame(8'h11, 1'b1);
    idle(5);
    checks++;
    if (rx_cnt - c0 !== 1 || rx_last !== 8'h11) begin
      failures++;
      $display("FAIL ferr_next cnt=%0d data=%h exp 1/11",
               rx_cnt - c0, rx_last);
    end
`ifdef UA_RX_FRAMING_ERR_EN
    checks++;
    if (rx_ferr !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clear got=%b exp=0", rx_ferr);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int c0;
    logic [7:0] b;
    c0 = rx_cnt;
    b = 8'hC3;
    SIn = 1'b0;
    idle(10);
    for (int i = 0; i < 4; i++) begin
      SIn = b[i];
      idle(10);
    end
    SIn = b[4];
    idle(4);
    Reset = 1'b0;
    idle(3);
    SIn = 1'b1;
    idle(3);
    Reset = 1'b1;
    idle(120);
    checks++;
    if (rx_cnt - c0 !== 0 || DataOutValid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset cnt=%0d valid=%b exp 0/0",
               rx_cnt - c0, DataOutValid);
    end
    send_frame(8'h7E, 1'b1);
    idle(5);
    checks++;
    if (rx_cnt - c0 !== 1 || rx_last !== 8'h7E) begin
      failures++;
      $display("FAIL mid_reset_next cnt=%0d data=%h exp 1/7e",
               rx_cnt - c0, rx_last);
    end
  endtask

  initial begin
    Reset = 1'b0;
    SIn = 1'b1;
    DataOutReady = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_false_start;
    test_framing;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ua_receive.md
Name: ua_receive

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmitter.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from serial input SIn.
- Presents each byte on a one-entry ready/valid output register.
- Sits between the board RX pin and the echo/consumer logic; timing parameters match the transmitter so one baud setting serves both.

Parameters:
- ClockFreq, 100_000_000, system clock frequency in Hz.
- BaudRate, 115_200, line rate in bits/s.
- SymbolEdgeTime (localparam), ClockFreq/BaudRate = 868 at defaults, clocks per bit.
- SampleTime (localparam), SymbolEdgeTime/2 = 434, mid-bit offset from the start edge.
- ClockCounterWidth (localparam), log2(SymbolEdgeTime).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- SIn  in  1  serial line; idle high; asynchronous to Clock.
- DataOut  out  8  received byte; stable while DataOutValid=1.
- DataOutValid  out  1  byte available.
- DataOutReady  in  1  consumer accepts; transfer when Valid&&Ready on a posedge.

Behaviour:
- Reset (Reset=0, asynchronous):
  - DataOutValid=0, DataOut=8'h00, state=IDLE, counters=0.
  - Synchronizer flops = 1 (idle line).
- SIn passes through a 2-flop synchronizer; all decisions use the synchronized value RxS.
- IDLE: on RxS=0 → go to START; ClockCounter=0, BitCounter=0.
- START: when ClockCounter==SampleTime-1, sample RxS:
  - RxS=1: false start → IDLE, nothing delivered.
  - RxS=0: → DATA; ClockCounter=0.
- DATA:
  - Each time ClockCounter==SymbolEdgeTime-1: shift RxS into bit 7 of the shift register (LSB-first), increment BitCounter, clear ClockCounter.
  - After the 8th sample → STOP.
- STOP: at ClockCounter==SymbolEdgeTime-1, sample the stop bit, then return to IDLE in the same cycle. IDLE can therefore detect the next start edge half a bit early, so back-to-back frames are supported.
  - Stop=1 and DataOutValid=0 (or being consumed this cycle): load DataOut; DataOutValid=1 next cycle.
  - Stop=1 and DataOutValid=1 and DataOutReady=0: overrun. New byte discarded; old byte and Valid retained.
  - Stop=0: framing error. Byte discarded (see Optional Feature).
- Output handshake:
  - Valid&&Ready clears DataOutValid next cycle, unless a new byte loads in the same cycle; then Valid stays 1 with the new data.
  - DataOut must not change while Valid=1 and not accepted.
- Latency: SIn falling edge → DataOutValid high = 2 (sync) + 1 + SampleTime + 9*SymbolEdgeTime clocks, ±1.
- Widths: ClockCounter is ClockCounterWidth bits; BitCounter is 4 bits; no wrap beyond terminal counts.
- SIn glitch shorter than SampleTime clocks: rejected by the START check.
- Reset asserted mid-frame: the frame is aborted. After release, the receiver waits for a fresh falling edge; a line held low at release is treated as a start.

Optional Feature:
- Macro UA_RX_FRAMING_ERR_EN.
- Defined:
  - Adds output port FrameError (1 bit).
  - A stop=0 frame is delivered like a good frame, with FrameError=1 alongside DataOutValid.
  - FrameError is 0 for good frames, follows the same hold/accept rules as DataOut, and resets to 0.
- Undefined: no port; stop=0 frames are silently dropped.

Decomposition:
- util.vh (existing): log2.
- New shared header ua_defs.vh:
  - State encodings IDLE/START/DATA/STOP (2-bit).
  - UA_DATA_BITS=8 and UA_FRAME_BITS=10, shared with the transmitter.
- One sub-module: ua_sync, a 2-flop synchronizer with parameterised reset value (1 here), reusable for other async inputs.

Test Plan (ClockFreq=1_000_000, BaudRate=100_000 → 10 clocks/bit):
- Reset: hold Reset=0 with SIn toggling → DataOutValid=0, DataOut=0. Release → no output while SIn=1.
- Single frame: drive 8'hA5 8N1 with DataOutReady=1 → DataOutValid pulses one cycle with DataOut=A5, about 2+1+5+90 clocks after the start edge.
- Back-to-back and hold: frames 8'h00 then 8'hFF with no idle gap, Ready=0 → Valid holds 00. Second frame is an overrun; DataOut stays 00. Assert Ready → Valid drops.
- False start: a 3-clock low pulse on SIn → no DataOutValid; receiver returns to IDLE. A following 8'h3C frame is received correctly.
- Framing error: 8'h5A with stop=0.
  - Macro undefined → no Valid.
  - Macro defined → Valid with DataOut=5A, FrameError=1.
  - Next good frame 8'h11 → FrameError=0.
- Reset mid-frame: assert Reset during data bit 4 of 8'hC3 → no output. Then 8'h7E → DataOut=7E.
